// File: rtl/alu_sliced_exec_if.sv
// Operand/result handshake bundle for the bit-sliced execute-stage ALU.
// The master drives operands and out_ready; the slave (ALU) returns the result.
interface alu_sliced_exec_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero
  );

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_sliced_exec.sv
// Execute-stage ALU processing SLICE bits per cycle, LSB slice first, with a
// registered carry between slices and valid/ready handshakes on both sides.
module alu_sliced_exec #(
  parameter int XLEN  = 32,
  parameter int SLICE = 8
) (
  input logic              clk,
  input logic              rst,
  alu_sliced_exec_if.slave bus
);
  localparam int NSL = XLEN / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic [3:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q, zero_q;

  logic            last_slice;
  logic [SLICE-1:0] a_s, b_s, slice_res;
  logic [SLICE:0]   slice_sum;
  logic [XLEN-1:0]  result_next, a_shift, b_shift;

  assign last_slice = (cnt_q == CW'(NSL - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
      S_RUN:   if (last_slice)    state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, with the +1 seeded into the carry at acceptance.
  always_comb begin
    a_s       = a_q[SLICE-1:0];
    b_s       = (op_q == OP_SUB) ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
    slice_sum = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
    case (op_q)
      OP_ADD, OP_SUB: slice_res = slice_sum[SLICE-1:0];
      OP_AND:         slice_res = a_s & b_s;
      default:        slice_res = a_s | b_s;
    endcase
  end

  generate
    if (NSL == 1) begin : g_single
      assign result_next = slice_res;
      assign a_shift     = '0;
      assign b_shift     = '0;
    end else begin : g_multi
      assign result_next = {slice_res, result_q[XLEN-1:SLICE]};
      assign a_shift     = {{SLICE{1'b0}}, a_q[XLEN-1:SLICE]};
      assign b_shift     = {{SLICE{1'b0}}, b_q[XLEN-1:SLICE]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          a_q     <= bus.src_a;
          b_q     <= bus.src_b;
          op_q    <= bus.alu_control;
          cnt_q   <= '0;
          carry_q <= (bus.alu_control == OP_SUB);
        end
        S_RUN: begin
          a_q      <= a_shift;
          b_q      <= b_shift;
          result_q <= result_next;
          carry_q  <= slice_sum[SLICE];
          cnt_q    <= cnt_q + CW'(1);
          if (last_slice) zero_q <= (result_next == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_sliced_exec.sv
// Directed and randomized bench for alu_sliced_exec, checked against a
// whole-word arithmetic reference model.
module tb_alu_sliced_exec;
  localparam int XLEN  = 32;
  localparam int SLICE = 8;
  localparam int NSL   = XLEN / SLICE;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_sliced_exec_if #(.XLEN(XLEN)) bus ();

  alu_sliced_exec #(.XLEN(XLEN), .SLICE(SLICE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns at the same phase.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int hold);
    int cycles;
    logic exp_z;
    exp_z = (exp_r == 32'h0);
    check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.src_a       = $urandom;
    bus.src_b       = $urandom;
    bus.alu_control = 4'($urandom);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'(NSL));
    check({tag, " result"}, bus.result, exp_r);
    check({tag, " zero"}, 32'(bus.zero), 32'(exp_z));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.src_a    = $urandom;
      bus.src_b    = $urandom;
      @(posedge clk); #1;
      check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, " hold result"}, bus.result, exp_r);
      check({tag, " hold zero"}, 32'(bus.zero), 32'(exp_z));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [3:0]  ops [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};

    rst = 1'b1;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.alu_control = 4'b0000;
    bus.src_a       = '0;
    bus.src_b       = '0;
    #2;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", bus.result, 32'h0);
    check("reset zero", 32'(bus.zero), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op("add 5+7",      4'b0010, 32'd5,        32'd7,        32'h0000000C, 0);
    run_op("add ff+1",     4'b0010, 32'h000000FF, 32'd1,        32'h00000100, 0);
    run_op("add wrap",     4'b0010, 32'hFFFFFFFF, 32'd1,        32'h00000000, 0);
    run_op("sub 3-3",      4'b0110, 32'd3,        32'd3,        32'h00000000, 0);
    run_op("sub 0-1",      4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, 0);
    run_op("and",          4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0);
    run_op("or",           4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0);
    run_op("code 0101",    4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0);
    run_op("hold done",    4'b0010, 32'h12345678, 32'h11111111, 32'h23456789, 10);
    run_op("sub borrow",   4'b0110, 32'h00010000, 32'd1,        32'h0000FFFF, 0);

    // Abort two cycles into RUN; the previous result is nonzero.
    bus.alu_control = 4'b0010;
    bus.src_a       = 32'h0000_0100;
    bus.src_b       = 32'h0000_0200;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort result", bus.result, 32'h0);
    check("abort zero", 32'(bus.zero), 32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort no out_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op("add 1+1", 4'b0010, 32'd1, 32'd1, 32'd2, 0);

    for (int i = 0; i < 40; i++) begin
      op = (i % 5 == 4) ? 4'($urandom) : ops[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFFFFFF;
        1:       a = 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op("random", op, a, b, ref_alu(op, a, b), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
